regfile_mp: RTL and testbench

- Parametrised multi-port integer register file; next generation of the core's 32x64 single-write regfile.
- Generalised in width, depth, read-port count and write-port count.
- Adds same-cycle write-to-read bypass on every port, a per-register pending scoreboard, and a sequential soft-clear sweep engine.
- Sits in the decode/writeback boundary of the pipeline; exports a flattened register image for co-simulation.

---
 rtl/regfile_mp.sv | 117 +++++++++++
 tb/tb_regfile_mp.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-port integer register file with write bypass, pending scoreboard
// and a sequential soft-clear sweep engine.
module regfile_mp #(
  parameter int XLEN  = 64,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int NWR   = 2,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NWR-1:0]        we,
  input  logic [NWR*AW-1:0]     waddr,
  input  logic [NWR*XLEN-1:0]   wdata,
  input  logic [NRD*AW-1:0]     raddr,
  input  logic [NRD-1:0]        rimm,
  output logic [NRD*XLEN-1:0]   rdata,
  output logic [NRD-1:0]        rpend,
  input  logic                  iss_valid,
  input  logic [AW-1:0]         iss_addr,
  input  logic                  clr_req,
  output logic                  clr_busy,
  output logic [NREGS*XLEN-1:0] cosim_regs
);

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  state_t            state, state_nx;
  logic [AW-1:0]     cnt;
  logic [XLEN-1:0]   regs [NREGS];
  logic [NREGS-1:0]  pend;
  logic              idle;
  logic [NRD-1:0]    hit;
  logic [XLEN-1:0]   byp [NRD];

  assign idle     = (state == IDLE);
  assign clr_busy = (state == SWEEP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (state == SWEEP)
        cnt <= cnt + 1'b1;
      else if (clr_req)
        cnt <= '0;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (clr_req) state_nx = SWEEP;
      SWEEP: if (cnt == AW'(NREGS - 1)) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Later ports overwrite earlier ones; the issue then overrides pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= '0;
      pend <= '0;
    end else if (state == SWEEP) begin
      regs[cnt] <= '0;
      pend[cnt] <= 1'b0;
    end else begin
      for (int k = 0; k < NWR; k++) begin
        if (we[k] && waddr[k*AW +: AW] != '0) begin
          regs[waddr[k*AW +: AW]] <= wdata[k*XLEN +: XLEN];
          pend[waddr[k*AW +: AW]] <= 1'b0;
        end
      end
      if (iss_valid && iss_addr != '0)
        pend[iss_addr] <= 1'b1;
    end
  end

  always_comb begin
    rdata = '0;
    rpend = '0;
    hit   = '0;
    byp   = '{default: '0};
    for (int j = 0; j < NRD; j++) begin
      for (int k = 0; k < NWR; k++) begin
        if (idle && we[k] &&
            waddr[k*AW +: AW] == raddr[j*AW +: AW]) begin
          hit[j] = 1'b1;
          byp[j] = wdata[k*XLEN +: XLEN];
        end
      end
      if (rimm[j]) begin
        rdata[j*XLEN +: XLEN] = XLEN'(raddr[j*AW +: AW]);
      end else if (raddr[j*AW +: AW] == '0) begin
        rdata[j*XLEN +: XLEN] = '0;
      end else if (hit[j]) begin
        rdata[j*XLEN +: XLEN] = byp[j];
      end else begin
        rdata[j*XLEN +: XLEN] = regs[raddr[j*AW +: AW]];
        rpend[j] = pend[raddr[j*AW +: AW]];
      end
    end
  end

  always_comb begin
    cosim_regs = '0;
    for (int i = 1; i < NREGS; i++)
      cosim_regs[i*XLEN +: XLEN] = regs[i];
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: directed scenarios plus randomized traffic
// checked against an array-based reference model.
module tb_regfile_mp;
  localparam int XLEN = 64, NREGS = 32, NRD = 2, NWR = 2, AW = 5;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NWR-1:0]        we;
  logic [NWR*AW-1:0]     waddr;
  logic [NWR*XLEN-1:0]   wdata;
  logic [NRD*AW-1:0]     raddr;
  logic [NRD-1:0]        rimm;
  logic [NRD*XLEN-1:0]   rdata;
  logic [NRD-1:0]        rpend;
  logic                  iss_valid;
  logic [AW-1:0]         iss_addr;
  logic                  clr_req;
  logic                  clr_busy;
  logic [NREGS*XLEN-1:0] cosim_regs;

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rimm(rimm), .rdata(rdata), .rpend(rpend),
    .iss_valid(iss_valid), .iss_addr(iss_addr), .clr_req(clr_req),
    .clr_busy(clr_busy), .cosim_regs(cosim_regs)
  );

  always #5 clk = ~clk;

  logic [XLEN-1:0] m_regs [NREGS];
  bit              m_pend [NREGS];
  bit              m_sweep;
  int              m_cnt;
  int              ncmp = 0;
  int              nerr = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) begin
      m_regs[i] = '0;
      m_pend[i] = 0;
    end
    m_sweep = 0;
    m_cnt   = 0;
  endtask

  function automatic logic [XLEN-1:0] exp_rd(input int j);
    logic [AW-1:0]   a;
    logic [XLEN-1:0] v;
    a = raddr[j*AW +: AW];
    if (rimm[j]) return XLEN'(a);
    if (a == 0) return '0;
    v = m_regs[a];
    if (!m_sweep)
      for (int k = 0; k < NWR; k++)
        if (we[k] && waddr[k*AW +: AW] == a) v = wdata[k*XLEN +: XLEN];
    return v;
  endfunction

  function automatic logic exp_rp(input int j);
    logic [AW-1:0] a;
    a = raddr[j*AW +: AW];
    if (rimm[j] || a == 0) return 1'b0;
    if (!m_sweep)
      for (int k = 0; k < NWR; k++)
        if (we[k] && waddr[k*AW +: AW] == a) return 1'b0;
    return m_pend[a];
  endfunction

  task automatic model_edge();
    logic [AW-1:0] a;
    if (m_sweep) begin
      m_regs[m_cnt] = '0;
      m_pend[m_cnt] = 0;
      if (m_cnt == NREGS - 1) begin
        m_sweep = 0;
        m_cnt   = 0;
      end else m_cnt++;
    end else begin
      for (int k = 0; k < NWR; k++) begin
        a = waddr[k*AW +: AW];
        if (we[k] && a != 0) begin
          m_regs[a] = wdata[k*XLEN +: XLEN];
          m_pend[a] = 0;
        end
      end
      if (iss_valid && iss_addr != 0) m_pend[iss_addr] = 1;
      if (clr_req) begin
        m_sweep = 1;
        m_cnt   = 0;
      end
    end
  endtask

  // Check combinational outputs, then clock one edge and advance the model.
  task automatic step();
    #1;
    for (int j = 0; j < NRD; j++) begin
      chk($sformatf("rdata%0d", j), rdata[j*XLEN +: XLEN], exp_rd(j));
      chk($sformatf("rpend%0d", j), 64'(rpend[j]), 64'(exp_rp(j)));
    end
    chk("clr_busy", 64'(clr_busy), 64'(m_sweep));
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check_cosim(input string tag);
    for (int i = 0; i < NREGS; i++)
      chk($sformatf("%s_r%0d", tag, i), cosim_regs[i*XLEN +: XLEN], m_regs[i]);
  endtask

  task automatic idle_in();
    we = '0; waddr = '0; wdata = '0; raddr = '0; rimm = '0;
    iss_valid = 0; iss_addr = '0; clr_req = 0;
  endtask

  task automatic wr(input int p, input int a, input logic [63:0] d);
    we[p] = 1'b1;
    waddr[p*AW +: AW] = AW'(a);
    wdata[p*XLEN +: XLEN] = d;
  endtask

  task automatic rd(input int p, input int a);
    raddr[p*AW +: AW] = AW'(a);
  endtask

  task automatic fill_all();
    for (int a = 1; a < NREGS; a++) begin
      idle_in();
      wr(0, a, {$urandom, $urandom});
      rd(0, a);
      step();
    end
    idle_in();
  endtask

  task automatic pulse_rst();
    rst = 1;
    #1;
    model_reset();
    chk("rst_busy", 64'(clr_busy), 64'(0));
    chk("rst_rd0", rdata[0 +: XLEN], 64'(0));
    chk("rst_rp0", 64'(rpend[0]), 64'(0));
    check_cosim("rst");
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  initial begin
    int n;
    idle_in();
    model_reset();
    rst = 1;
    #12 rst = 0;
    @(posedge clk);
    #1;

    // Reset with preloaded, pending registers
    fill_all();
    iss_valid = 1; iss_addr = 9;
    step();
    idle_in();
    rd(0, 5); rd(1, 9);
    pulse_rst();
    idle_in();
    rd(0, 9); rd(1, 5);
    step();

    // Write with same-cycle bypass; writes to x0 dropped
    wr(0, 5, 64'hDEAD_BEEF); rd(0, 5);
    wr(1, 0, 64'h1234); rd(1, 0);
    #1;
    chk("byp5", rdata[0 +: XLEN], 64'hDEAD_BEEF);
    chk("x0_byp", rdata[XLEN +: XLEN], 64'h0);
    step();
    idle_in();
    rd(0, 5); rd(1, 0);
    #1;
    chk("st5", rdata[0 +: XLEN], 64'hDEAD_BEEF);
    chk("x0_st", rdata[XLEN +: XLEN], 64'h0);
    step();

    // Dual-write conflict: higher port wins
    wr(0, 7, 64'h11); wr(1, 7, 64'h22); rd(0, 7); rd(1, 7);
    #1;
    chk("conf_byp0", rdata[0 +: XLEN], 64'h22);
    chk("conf_byp1", rdata[XLEN +: XLEN], 64'h22);
    step();
    idle_in();
    rd(0, 7); rd(1, 7);
    #1;
    chk("conf_st0", rdata[0 +: XLEN], 64'h22);
    chk("conf_st1", rdata[XLEN +: XLEN], 64'h22);
    step();

    // Scoreboard
    iss_valid = 1; iss_addr = 3;
    step();
    idle_in();
    rd(0, 3);
    #1;
    chk("pend3", 64'(rpend[0]), 64'(1));
    step();
    wr(1, 3, 64'h77); rd(0, 3);
    #1;
    chk("pend3_byp", 64'(rpend[0]), 64'(0));
    step();
    idle_in();
    iss_valid = 1; iss_addr = 3; wr(1, 3, 64'hABC);
    step();
    idle_in();
    rd(0, 3);
    #1;
    chk("iss_wr_pend", 64'(rpend[0]), 64'(1));
    chk("iss_wr_data", rdata[0 +: XLEN], 64'hABC);
    step();

    // Immediate mode
    wr(0, 9, 64'h55);
    step();
    idle_in();
    rimm = 2'b10; rd(1, 9); rd(0, 9);
    #1;
    chk("imm_data", rdata[XLEN +: XLEN], 64'd9);
    chk("imm_pend", 64'(rpend[1]), 64'(0));
    chk("imm_other", rdata[0 +: XLEN], 64'h55);
    step();
    idle_in();

    // Soft clear: same-cycle write is performed then swept
    fill_all();
    clr_req = 1; wr(0, 4, 64'h44);
    step();
    n = 0;
    for (int i = 0; i < 100; i++) begin
      if (!clr_busy) break;
      n++;
      idle_in();
      wr(0, $urandom_range(1, NREGS - 1), {$urandom, $urandom});
      wr(1, $urandom_range(1, NREGS - 1), {$urandom, $urandom});
      iss_valid = 1; iss_addr = AW'($urandom_range(1, NREGS - 1));
      rd(0, $urandom_range(0, NREGS - 1)); rd(1, $urandom_range(0, NREGS - 1));
      clr_req = ($urandom_range(0, 3) == 0);
      step();
    end
    idle_in();
    chk("sweep_len", 64'(n), 64'(NREGS));
    chk("swept_r4", cosim_regs[4*XLEN +: XLEN], 64'h0);
    check_cosim("sweep");

    // Reset in the middle of a sweep
    fill_all();
    clr_req = 1;
    step();
    idle_in();
    repeat (10) step();
    chk("mid_busy", 64'(clr_busy), 64'(1));
    pulse_rst();
    idle_in();

    // Randomized traffic
    for (int t = 0; t < 600; t++) begin
      idle_in();
      for (int k = 0; k < NWR; k++)
        if ($urandom_range(0, 1)) wr(k, $urandom_range(0, 7), {$urandom, $urandom});
      for (int j = 0; j < NRD; j++) rd(j, $urandom_range(0, 7));
      rimm      = NRD'($urandom_range(0, 3) == 0 ? $urandom : 0);
      iss_valid = $urandom_range(0, 2) == 0;
      iss_addr  = AW'($urandom_range(0, 7));
      clr_req   = $urandom_range(0, 79) == 0;
      step();
      if (t % 100 == 99) check_cosim("rnd");
    end
    idle_in();
    for (int i = 0; i < 40 && m_sweep; i++) step();
    check_cosim("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
